pc_if: RTL
==========

# pc_if

Instruction-fetch stage with integrated PC register and IF/ID pipeline register. It sits directly upstream of the decode stage and drives that stage's `pc_id`/`inst_id` inputs. Its `branch_flag`/`branch_target_address` outputs loop back here. It issues one outstanding request at a time to instruction memory over a req/ack handshake. It holds fetched instructions while decode is stalled and honours MIPS branch-delay-slot ordering.

## Interface
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset
- `NOP_INST`, 32'h0000_0000, instruction presented to decode when no valid instruction is held
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `stall_i`  in  1  decode/downstream stall; IF/ID register must not advance while high
- `branch_flag_i`  in  1  decode stage resolved a taken branch for the instruction currently in `inst_id`
- `branch_target_address_i`  in  32  target of that branch
- `inst_req_o`  out  1  fetch request, held until acknowledged
- `inst_addr_o`  out  32  fetch address, stable while `inst_req_o` high
- `inst_ack_i`  in  1  memory accepted request; `inst_rdata_i` valid this cycle
- `inst_rdata_i`  in  32  fetched instruction word
- `pc_id`  out  32  PC of instruction held in IF/ID
- `inst_id`  out  32  instruction held in IF/ID (`NOP_INST` when invalid)
- `inst_valid_o`  out  1  IF/ID holds a real instruction

## Operation
- Registers:
  - `fetch_pc`, the address of the next or in-flight fetch.
  - IF/ID (`pc_id`, `inst_id`, valid).
  - Skid buffer: one entry of pc, inst and valid.
  - `br_pend` and `br_target`.
- FSM states:
  - `BOOT`: first cycle after reset release. `inst_req_o`=0; goes to `FETCH`.
  - `FETCH`: `inst_req_o`=1 and `inst_addr_o`=`fetch_pc`.
    - On ack with IF/ID able to accept (`!inst_valid_o || !stall_i`): the word loads into IF/ID and the FSM stays in `FETCH` with the next address.
    - On ack with IF/ID full and stalled: the word goes to the skid buffer and the FSM goes to `HOLD`.
  - `HOLD`: `inst_req_o`=0.
    - When `stall_i` drops, the skid entry moves into IF/ID and the FSM returns to `FETCH` the next cycle.
- Next `fetch_pc` after an ack:
  - `br_target` if `br_pend`=1; `br_pend` then clears.
  - Otherwise `fetch_pc+4`.
- Branch capture:
  - Condition: `branch_flag_i && inst_valid_o && !stall_i`, i.e. the branch leaves decode.
  - Action: set `br_pend` and latch `br_target`.
  - The fetch in flight or next issued at `pc_id+4` is the delay slot; it completes normally. Only the following fetch uses the target.
- `branch_flag_i` while `stall_i`=1 is ignored; the branch is re-presented until it advances.
- Branch capture and an ack in the same cycle:
  - If the acked address ≠ the delay-slot address, the next fetch goes to `fetch_pc+4`. This case cannot occur with single-outstanding ordering; the bench asserts it never happens.
  - Otherwise the next fetch goes directly to the target.
- When IF/ID advances with no new word available, it loads valid=0, `inst_id`=`NOP_INST` (bubble).

## Timing
- Reset values:
  - `inst_req_o`=0, `inst_addr_o`=`RESET_PC`, `pc_id`=0, `inst_id`=`NOP_INST`, `inst_valid_o`=0.
  - `br_pend`=0; FSM=`BOOT`.
- First request: second rising edge after `rst` deasserts.
- Latency and throughput with zero-wait memory:
  - Ack in the cycle of request gives one instruction per cycle.
  - `inst_id` updates the edge after ack.
- `inst_addr_o` may change only on the edge following an ack. It must never change while a request is unacknowledged, including across a branch capture.
- Reset mid-request: all state clears immediately. The late ack is discarded because `inst_req_o` is already 0 after reset, and the memory side must drop it.
- Stall with IF/ID and skid both full: no request is outstanding, so no further fetch is possible and no overflow can occur.
- `pc_id` wraps modulo 2^32 (`32'hFFFF_FFFC`+4 = 0).

## Configuration
- `PC_IF_ALIGN_CHECK_EN` defined:
  - A fetch address with `[1:0]`≠0 is not requested.
  - The stage instead produces an IF/ID entry with `inst_id`=`NOP_INST`, `inst_valid_o`=1, and an extra output `inst_adel_o`=1 carrying the bad PC in `pc_id`.
  - Fetching then halts in `HOLD` until reset.
- Undefined: no check, no `inst_adel_o` port; the low address bits pass through unmodified.

## Structure
- Shared package: `RESET_PC` default, `NOP_INST`, FSM state enum (`BOOT`/`FETCH`/`HOLD`), and the 32-bit word width constant.
- One natural sub-module, `if_skid_buf`: the single-entry pc+inst buffer with load/unload controls. The rest is flat.

## Test plan
- Reset release, memory acks every cycle → requests at `BFC00000`, `BFC00004`, `BFC00008`; `inst_id` follows one cycle after each ack; `inst_valid_o`=1 from third edge.
- Ack delayed 3 cycles for `BFC00004` → `inst_addr_o` stable for 4 cycles; decode sees a bubble (`inst_valid_o`=0, `inst_id`=0) for 3 cycles.
- `stall_i` high 5 cycles while fetching → one word captured in skid; `inst_req_o` low in `HOLD`; after release, words delivered in order with no loss or duplicate.
- Branch at `pc_id`=`BFC00010`, target `BFC00100` → next decoded PCs are `BFC00014` (delay slot) then `BFC00100`.
- Branch flag held during a 2-cycle stall, then released → target captured once; fetch sequence identical to the unstalled case.
- `PC_IF_ALIGN_CHECK_EN` defined, branch target `BFC00102` → no request to `BFC00102`; `inst_adel_o`=1 with `pc_id`=`BFC00102`; `inst_req_o` stays 0 afterwards.

Source files
------------

// File: rtl/pc_if_pkg.sv
// Shared types and constants for the pc_if instruction-fetch stage.
// Build option: PC_IF_ALIGN_CHECK_EN adds fetch-address alignment trapping.
package pc_if_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_IF_RESET_PC = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] PC_IF_NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } if_state_e;

  // One fetched slot: IF/ID register and skid entry share this layout.
  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_entry_t;

endpackage

// File: rtl/pc_if_skid_buf.sv
// Single-entry pc+inst buffer that catches a word acked while IF/ID is stalled.
// Load has priority over unload; contents are don't-care once vld is low.
module if_skid_buf
  import pc_if_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = PC_IF_NOP
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      unload,
  input  if_entry_t din,
  output if_entry_t dout
);

  if_entry_t q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '{vld: 1'b0, pc: '0, inst: NOP_INST};
    end else if (load) begin
      q <= din;
    end else if (unload) begin
      q.vld <= 1'b0;
    end
  end

  assign dout = q;

endmodule

// File: rtl/pc_if.sv
// Instruction-fetch stage: PC register, single-outstanding fetch FSM, IF/ID register.
// Build option: PC_IF_ALIGN_CHECK_EN (misaligned fetch -> inst_adel_o entry, fetch halts).
module pc_if
  import pc_if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = PC_IF_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INST = PC_IF_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            branch_flag_i,
  input  logic [XLEN-1:0] branch_target_address_i,
  output logic            inst_req_o,
  output logic [XLEN-1:0] inst_addr_o,
  input  logic            inst_ack_i,
  input  logic [XLEN-1:0] inst_rdata_i,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] inst_id,
  output logic            inst_valid_o
`ifdef PC_IF_ALIGN_CHECK_EN
  ,
  output logic            inst_adel_o
`endif
);

  if_state_e       state, state_n;
  logic            rst_done;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic            br_pend, br_pend_n;
  logic [XLEN-1:0] br_target, br_target_n;
  if_entry_t       id_q, id_n;
  if_entry_t       skid_q, ack_entry;
  logic            skid_load, skid_unload;
  logic            req;
  logic            can_acc, br_take, ds_hit, acked, halted;
  logic [XLEN-1:0] ds_pc, pc_after_ack;

`ifdef PC_IF_ALIGN_CHECK_EN
  logic adel_q, adel_n, halt_q, halt_n, misalign;
  assign misalign = (fetch_pc[1:0] != 2'b00);
  assign halted   = halt_q;
`else
  assign halted   = 1'b0;
`endif

  assign can_acc   = !id_q.vld || !stall_i;
  assign br_take   = branch_flag_i && id_q.vld && !stall_i;
  assign ds_pc     = id_q.pc + 32'd4;
  assign ds_hit    = (fetch_pc == ds_pc);
  assign acked     = req && inst_ack_i;
  assign ack_entry = '{vld: 1'b1, pc: fetch_pc, inst: inst_rdata_i};

  // A branch leaving decode while its delay slot is being acked jumps straight to the target.
  assign pc_after_ack = br_pend             ? br_target :
                        (br_take && ds_hit) ? branch_target_address_i :
                                              fetch_pc + 32'd4;

  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    br_pend_n   = br_pend;
    br_target_n = br_target;
    id_n        = id_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    req         = 1'b0;
`ifdef PC_IF_ALIGN_CHECK_EN
    adel_n      = can_acc ? 1'b0 : adel_q;
    halt_n      = halt_q;
`endif
    // IF/ID advancing with nothing new becomes a bubble.
    if (can_acc) id_n = '{vld: 1'b0, pc: id_q.pc, inst: NOP_INST};

    case (state)
      BOOT: if (rst_done) state_n = FETCH;
      FETCH: begin
        req = 1'b1;
`ifdef PC_IF_ALIGN_CHECK_EN
        if (misalign) begin
          req = 1'b0;
          if (can_acc) begin
            id_n    = '{vld: 1'b1, pc: fetch_pc, inst: NOP_INST};
            adel_n  = 1'b1;
            halt_n  = 1'b1;
            state_n = HOLD;
          end
        end else
`endif
        if (inst_ack_i) begin
          fetch_pc_n = pc_after_ack;
          if (can_acc) begin
            id_n = ack_entry;
          end else begin
            skid_load = 1'b1;
            state_n   = HOLD;
          end
        end
      end
      HOLD: begin
        if (!halted && !stall_i) begin
          id_n        = skid_q;
          skid_unload = 1'b1;
          state_n     = FETCH;
        end
      end
      default: state_n = BOOT;
    endcase

    if (acked && br_pend) br_pend_n = 1'b0;
    if (br_take && !(acked && ds_hit)) begin
      // In HOLD the delay slot already sits in the skid and nothing is in flight,
      // so the stale sequential address is replaced before fetch resumes.
      if (state == HOLD && !ds_hit) begin
        fetch_pc_n = branch_target_address_i;
      end else begin
        br_pend_n   = 1'b1;
        br_target_n = branch_target_address_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BOOT;
      rst_done  <= 1'b0;
      fetch_pc  <= RESET_PC;
      br_pend   <= 1'b0;
      br_target <= '0;
      id_q      <= '{vld: 1'b0, pc: '0, inst: NOP_INST};
    end else begin
      state     <= state_n;
      rst_done  <= 1'b1;
      fetch_pc  <= fetch_pc_n;
      br_pend   <= br_pend_n;
      br_target <= br_target_n;
      id_q      <= id_n;
    end
  end

`ifdef PC_IF_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adel_q <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      adel_q <= adel_n;
      halt_q <= halt_n;
    end
  end

  assign inst_adel_o = adel_q;
`endif

  if_skid_buf #(.NOP_INST(NOP_INST)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .unload (skid_unload),
    .din    (ack_entry),
    .dout   (skid_q)
  );

  assign inst_req_o   = req;
  assign inst_addr_o  = fetch_pc;
  assign pc_id        = id_q.pc;
  assign inst_id      = id_q.inst;
  assign inst_valid_o = id_q.vld;

endmodule
